window_stream_gen: RTL and testbench

- Streaming hardware replacement for the software 3x3 window builder used by the denoising bench.
- Accepts a raster-order pixel stream, one pixel per beat, and emits one WIN x WIN zero-padded neighbourhood per input pixel.
- Output order matches input order; windows feed the decision-tree denoiser core directly.
- Generalised over pixel width, image size and odd window size. Adds valid/ready backpressure and an automatic end-of-frame flush.

---
 rtl/window_pkg.sv | 26 ++
 rtl/window_stream_gen_line_buffer.sv | 24 ++
 rtl/window_stream_gen.sv | 216 +++++++++++++++++++++
 tb/tb_window_stream_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared state encodings and index helpers for the streaming window generator.
package window_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_FILL  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_FLUSH = 2'd2;

   localparam int unsigned CNT_W = 16;

   function automatic int unsigned calc_k(input int unsigned win);
      return (win - 1) / 2;
   endfunction

   // Pixels that must be accepted before the first window centre exists.
   function automatic int unsigned calc_l(input int unsigned win, input int unsigned img_w);
      return calc_k(win) * img_w + calc_k(win);
   endfunction

   function automatic int unsigned tap(input int unsigned r, input int unsigned c,
                                       input int unsigned win);
      return r * win + c;
   endfunction

endpackage

// File: rtl/window_stream_gen_line_buffer.sv
// One image row of delay: circular RAM, read-before-write at a shared column pointer.
module line_buffer #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 512,
   parameter int unsigned PTR_W = 9
) (
   input  logic             iClk,
   input  logic             iEn,
   input  logic [PTR_W-1:0] ivPtr,
   input  logic [PIX_W-1:0] ivData,
   output logic [PIX_W-1:0] ovData
);

   logic [PIX_W-1:0] mem_q [IMG_W];

   assign ovData = mem_q[ivPtr];

   always_ff @(posedge iClk) begin
      if (iEn) begin
         mem_q[ivPtr] <= ivData;
      end
   end

endmodule

// File: rtl/window_stream_gen.sv
// Raster pixel stream in, one zero-padded WIN x WIN neighbourhood per pixel out,
// with valid/ready on both sides and an automatic end-of-frame flush.
module window_stream_gen
   import window_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 512,
   parameter int unsigned IMG_H = 512,
   parameter int unsigned WIN   = 3
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iDataValid,
   output logic                     oReady,
   input  logic [PIX_W-1:0]         ivPixel,
   output logic [WIN*WIN*PIX_W-1:0] ovWindow,
   output logic                     oValid,
   input  logic                     iReady,
   output logic [15:0]              ovRow,
   output logic [15:0]              ovCol,
   output logic                     oEof
);

   localparam int unsigned K     = calc_k(WIN);
   localparam int unsigned L     = calc_l(WIN, IMG_W);
   localparam int unsigned NTAP  = WIN * WIN;
   localparam int unsigned WIN_W = NTAP * PIX_W;
   localparam int unsigned NLB   = WIN - 1;
   localparam int unsigned PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] FILL_ROW = CNT_W'((L - 1) / IMG_W);
   localparam logic [CNT_W-1:0] FILL_COL = CNT_W'((L - 1) % IMG_W);

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   in_row_q, in_row_d, in_col_q, in_col_d;
   logic [CNT_W-1:0]   out_row_q, out_row_d, out_col_q, out_col_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [WIN_W-1:0]   owin_q, owin_d;
   logic [CNT_W-1:0]   orow_q, orow_d, ocol_q, ocol_d;
   logic               valid_q, valid_d, eof_q, eof_d;

   logic               accept, flush_beat, advance, produce, taken;
   logic [PIX_W-1:0]   pix_in;
   logic [WIN_W-1:0]   shift_win, mask_win;
   logic [PIX_W-1:0]   col_in [WIN];
   logic [PIX_W-1:0]   lb_out [NLB];

   assign oReady     = !iRst && (state_q != ST_FLUSH) && (!valid_q || iReady);
   assign accept     = iDataValid && oReady;
   assign taken      = valid_q && iReady;
   // Flush beats stop once the end-of-frame window is waiting to be taken.
   assign flush_beat = (state_q == ST_FLUSH) && (!valid_q || iReady) && !eof_q;
   assign advance    = accept || flush_beat;
   assign produce    = (accept && (state_q == ST_RUN)) || flush_beat;
   assign pix_in     = flush_beat ? '0 : ivPixel;

   assign col_in[WIN-1] = pix_in;

   for (genvar i = 0; i < NLB; i++) begin : g_lb
      logic [PIX_W-1:0] lb_in;
      if (i == 0) begin : g_first
         assign lb_in = pix_in;
      end else begin : g_next
         assign lb_in = lb_out[i-1];
      end
      line_buffer #(
         .PIX_W (PIX_W),
         .IMG_W (IMG_W),
         .PTR_W (PTR_W)
      ) u_lb (
         .iClk   (iClk),
         .iEn    (advance),
         .ivPtr  (ptr_q),
         .ivData (lb_in),
         .ovData (lb_out[i])
      );
      assign col_in[WIN-2-i] = lb_out[i];
   end

   // Shift the register window one column left and load the new right column.
   always_comb begin
      shift_win = win_q;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN - 1; c++) begin
            shift_win[tap(r, c, WIN)*PIX_W +: PIX_W] = win_q[tap(r, c + 1, WIN)*PIX_W +: PIX_W];
         end
         shift_win[tap(r, WIN - 1, WIN)*PIX_W +: PIX_W] = col_in[r];
      end
   end

   // Zero taps outside the image using the output coordinate, never buffer data.
   always_comb begin
      int ir;
      int ic;
      ir       = 0;
      ic       = 0;
      mask_win = shift_win;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            ir = int'(out_row_q) + r - int'(K);
            ic = int'(out_col_q) + c - int'(K);
            if (ir < 0 || ir >= int'(IMG_H) || ic < 0 || ic >= int'(IMG_W)) begin
               mask_win[tap(r, c, WIN)*PIX_W +: PIX_W] = '0;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      in_row_d  = in_row_q;
      in_col_d  = in_col_q;
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      win_d     = win_q;
      owin_d    = owin_q;
      orow_d    = orow_q;
      ocol_d    = ocol_q;
      valid_d   = valid_q;
      eof_d     = eof_q;

      if (advance) begin
         win_d = shift_win;
         ptr_d = (ptr_q == PTR_W'(IMG_W - 1)) ? '0 : ptr_q + PTR_W'(1);
      end

      if (accept) begin
         in_col_d = (in_col_q == LAST_COL) ? '0 : in_col_q + CNT_W'(1);
         if (in_col_q == LAST_COL) begin
            in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + CNT_W'(1);
         end
      end

      if (taken) begin
         valid_d = 1'b0;
         eof_d   = 1'b0;
      end

      if (produce) begin
         owin_d    = mask_win;
         orow_d    = out_row_q;
         ocol_d    = out_col_q;
         valid_d   = 1'b1;
         eof_d     = (out_row_q == LAST_ROW) && (out_col_q == LAST_COL);
         out_col_d = (out_col_q == LAST_COL) ? '0 : out_col_q + CNT_W'(1);
         if (out_col_q == LAST_COL) begin
            out_row_d = (out_row_q == LAST_ROW) ? '0 : out_row_q + CNT_W'(1);
         end
      end

      case (state_q)
         ST_FILL: begin
            if (accept && in_row_q == FILL_ROW && in_col_q == FILL_COL) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept && in_row_q == LAST_ROW && in_col_q == LAST_COL) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (taken && eof_q) begin
               state_d   = ST_FILL;
               ptr_d     = '0;
               in_row_d  = '0;
               in_col_d  = '0;
               out_row_d = '0;
               out_col_d = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q   <= ST_FILL;
         ptr_q     <= '0;
         in_row_q  <= '0;
         in_col_q  <= '0;
         out_row_q <= '0;
         out_col_q <= '0;
         win_q     <= '0;
         owin_q    <= '0;
         orow_q    <= '0;
         ocol_q    <= '0;
         valid_q   <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         in_row_q  <= in_row_d;
         in_col_q  <= in_col_d;
         out_row_q <= out_row_d;
         out_col_q <= out_col_d;
         win_q     <= win_d;
         owin_q    <= owin_d;
         orow_q    <= orow_d;
         ocol_q    <= ocol_d;
         valid_q   <= valid_d;
         eof_q     <= eof_d;
      end
   end

   assign ovWindow = owin_q;
   assign ovRow    = orow_q;
   assign ovCol    = ocol_q;
   assign oValid   = valid_q;
   assign oEof     = eof_q;

endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen on a 4x4 image with a 3x3 window.
module tb_window_stream_gen;

   localparam int PW = 8;
   localparam int IW = 4;
   localparam int IH = 4;
   localparam int W  = 3;
   localparam int K  = (W - 1) / 2;
   localparam int NP = IW * IH;
   localparam int WW = W * W * PW;

   logic          iClk = 1'b0;
   logic          iRst;
   logic          iDataValid;
   logic          oReady;
   logic [PW-1:0] ivPixel;
   logic [WW-1:0] ovWindow;
   logic          oValid;
   logic          iReady;
   logic [15:0]   ovRow;
   logic [15:0]   ovCol;
   logic          oEof;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int            row;
      int            col;
      logic [WW-1:0] win;
      logic          eof;
   } vec_t;

   vec_t          tbl [7];
   logic [WW-1:0] cap_win [NP];
   logic [15:0]   cap_row [NP];
   logic [15:0]   cap_col [NP];
   logic          cap_eof [NP];

   window_stream_gen #(
      .PIX_W (PW),
      .IMG_W (IW),
      .IMG_H (IH),
      .WIN   (W)
   ) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iDataValid (iDataValid),
      .oReady     (oReady),
      .ivPixel    (ivPixel),
      .ovWindow   (ovWindow),
      .oValid     (oValid),
      .iReady     (iReady),
      .ovRow      (ovRow),
      .ovCol      (ovCol),
      .oEof       (oEof)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] pk(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
      return {PW'(a8), PW'(a7), PW'(a6), PW'(a5), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
   endfunction

   // Software zero-padded neighbourhood; pixel (r,c) of a frame is base + r*IW + c + 1.
   function automatic logic [WW-1:0] model(input int base, input int r, input int c);
      logic [WW-1:0] w;
      w = '0;
      for (int dr = -K; dr <= K; dr++) begin
         for (int dc = -K; dc <= K; dc++) begin
            int rr;
            int cc;
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < IH && cc >= 0 && cc < IW)
               w[((dr + K) * W + (dc + K)) * PW +: PW] = PW'(base + rr * IW + cc + 1);
         end
      end
      return w;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_oReady"}, WW'(oReady), '0);
      chk({tag, "_oValid"}, WW'(oValid), '0);
      chk({tag, "_oEof"}, WW'(oEof), '0);
      chk({tag, "_ovWindow"}, ovWindow, '0);
      chk({tag, "_ovRow"}, WW'(ovRow), '0);
      chk({tag, "_ovCol"}, WW'(ovCol), '0);
   endtask

   task automatic run_frame(input int base, input bit stall, input bit cap, input bit lat);
      int            pix;
      int            nwin;
      int            cyc;
      int            acc6;
      int            first_v;
      bit            held;
      logic [WW-1:0] h_win;
      logic [15:0]   h_row;
      logic [15:0]   h_col;
      logic          h_eof;
      pix = 0; nwin = 0; cyc = 0; acc6 = -1; first_v = -1; held = 1'b0;
      h_win = '0; h_row = '0; h_col = '0; h_eof = 1'b0;
      while (nwin < NP && cyc < 2000) begin
         @(negedge iClk);
         iDataValid = (pix < NP) && (!stall || $urandom_range(0, 9) >= 3);
         ivPixel    = PW'(base + pix + 1);
         iReady     = !stall || ($urandom_range(0, 9) >= 3);
         #1;
         if (held) begin
            chk($sformatf("stall_valid_b%0d_w%0d", base, nwin), WW'(oValid), WW'(1));
            chk($sformatf("stall_win_b%0d_w%0d", base, nwin), ovWindow, h_win);
            chk($sformatf("stall_row_b%0d_w%0d", base, nwin), WW'(ovRow), WW'(h_row));
            chk($sformatf("stall_col_b%0d_w%0d", base, nwin), WW'(ovCol), WW'(h_col));
            chk($sformatf("stall_eof_b%0d_w%0d", base, nwin), WW'(oEof), WW'(h_eof));
         end
         if (pix == NP)
            chk($sformatf("flush_oready_b%0d_c%0d", base, cyc), WW'(oReady), '0);
         if (oValid && first_v < 0) first_v = cyc;
         if (oValid && iReady) begin
            chk($sformatf("win_b%0d_i%0d", base, nwin), ovWindow, model(base, nwin / IW, nwin % IW));
            chk($sformatf("row_b%0d_i%0d", base, nwin), WW'(ovRow), WW'(nwin / IW));
            chk($sformatf("col_b%0d_i%0d", base, nwin), WW'(ovCol), WW'(nwin % IW));
            chk($sformatf("eof_b%0d_i%0d", base, nwin), WW'(oEof), WW'(nwin == NP - 1));
            if (cap) begin
               cap_win[nwin] = ovWindow;
               cap_row[nwin] = ovRow;
               cap_col[nwin] = ovCol;
               cap_eof[nwin] = oEof;
            end
            nwin++;
         end
         held  = oValid && !iReady;
         h_win = ovWindow;
         h_row = ovRow;
         h_col = ovCol;
         h_eof = oEof;
         if (iDataValid && oReady) begin
            if (pix == 5) acc6 = cyc;
            pix++;
         end
         cyc++;
      end
      chk($sformatf("window_count_b%0d", base), WW'(nwin), WW'(NP));
      chk($sformatf("pixel_count_b%0d", base), WW'(pix), WW'(NP));
      if (lat) chk("first_valid_after_pixel6", WW'(first_v), WW'(acc6 + 1));
   endtask

   initial begin
      int pix;
      int cyc;

      tbl[0] = '{0, 0, pk(0, 0, 0, 0, 1, 2, 0, 5, 6), 1'b0};
      tbl[1] = '{1, 1, pk(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
      tbl[2] = '{1, 2, pk(2, 3, 4, 6, 7, 8, 10, 11, 12), 1'b0};
      tbl[3] = '{2, 3, pk(7, 8, 0, 11, 12, 0, 15, 16, 0), 1'b0};
      tbl[4] = '{3, 3, pk(11, 12, 0, 15, 16, 0, 0, 0, 0), 1'b1};
      tbl[5] = '{0, 3, pk(0, 0, 0, 3, 4, 0, 7, 8, 0), 1'b0};
      tbl[6] = '{3, 0, pk(0, 9, 10, 0, 13, 14, 0, 0, 0), 1'b0};

      iRst = 1'b1; iDataValid = 1'b0; iReady = 1'b0; ivPixel = '0;
      repeat (3) @(negedge iClk);
      #1;
      chk_reset_outputs("reset");
      @(negedge iClk);
      iRst = 1'b0;

      run_frame(0, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 7; i++) begin
         int idx;
         idx = tbl[i].row * IW + tbl[i].col;
         chk($sformatf("tbl_win_%0d_%0d", tbl[i].row, tbl[i].col), cap_win[idx], tbl[i].win);
         chk($sformatf("tbl_row_%0d_%0d", tbl[i].row, tbl[i].col), WW'(cap_row[idx]), WW'(tbl[i].row));
         chk($sformatf("tbl_col_%0d_%0d", tbl[i].row, tbl[i].col), WW'(cap_col[idx]), WW'(tbl[i].col));
         chk($sformatf("tbl_eof_%0d_%0d", tbl[i].row, tbl[i].col), WW'(cap_eof[idx]), WW'(tbl[i].eof));
      end

      // Back-to-back second frame with random stalls on both sides.
      run_frame(100, 1'b1, 1'b0, 1'b0);

      // Abort a frame after 7 pixels, then replay a full frame.
      pix = 0; cyc = 0;
      while (pix < 7 && cyc < 100) begin
         @(negedge iClk);
         iDataValid = 1'b1;
         iReady     = 1'b1;
         ivPixel    = PW'(50 + pix + 1);
         #1;
         if (oReady) pix++;
         cyc++;
      end
      chk("abort_pixels_fed", WW'(pix), WW'(7));
      @(negedge iClk);
      iDataValid = 1'b0;
      iRst       = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      repeat (2) @(negedge iClk);
      #1;
      chk_reset_outputs("midreset_hold");
      iRst = 1'b0;

      run_frame(200, 1'b0, 1'b0, 1'b0);
      run_frame(30, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
